// File: rtl/register_serial_reader_if.sv
// Load/stream handshake bundle for register_serial_reader.
// master drives loads and bit_ready; slave is the serializer.
interface register_serial_reader_if #(
    parameter int unsigned n = 32
);
    logic         ld_valid;
    logic [n-1:0] ld_data;
    logic         ld_ready;
    logic         bit_valid;
    logic         bit_data;
    logic         bit_last;
    logic         bit_ready;
    logic         busy;
    logic         done;

    modport master (
        output ld_valid, ld_data, bit_ready,
        input  ld_ready, bit_valid, bit_data, bit_last, busy, done
    );

    modport slave (
        input  ld_valid, ld_data, bit_ready,
        output ld_ready, bit_valid, bit_data, bit_last, busy, done
    );
endinterface

// File: rtl/register_serial_reader.sv
// Loads an n-bit word over valid/ready and streams it out LSB first, one bit per handshake.
// Define REGISTER_SERIAL_READER_PARITY_EN to append an even-parity bit after the data bits.
module register_serial_reader #(
    parameter int unsigned n = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    register_serial_reader_if.slave bus
);
    localparam int unsigned   CW   = $clog2(n);
    localparam logic [CW-1:0] LAST = CW'(n - 1);

`ifdef REGISTER_SERIAL_READER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

    state_t        state, state_nxt;
    logic [n-1:0]  shreg;
    logic [CW-1:0] cnt;
    logic          done_q;
    logic          valid;
    logic          xfer;
    logic          last_data;
    logic          load;
    logic          finish;
`ifdef REGISTER_SERIAL_READER_PARITY_EN
    logic          par_q;
`endif

    assign valid     = (state != IDLE);
    assign xfer      = valid && bus.bit_ready;
    assign last_data = (state == SHIFT) && (cnt == LAST);
    assign load      = bus.ld_valid && bus.ld_ready;

`ifdef REGISTER_SERIAL_READER_PARITY_EN
    assign finish = xfer && (state == PARITY);
`else
    assign finish = xfer && last_data;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = SHIFT;
`ifdef REGISTER_SERIAL_READER_PARITY_EN
            SHIFT:   if (xfer && last_data) state_nxt = PARITY;
            PARITY:  if (xfer) state_nxt = IDLE;
`else
            SHIFT:   if (xfer && last_data) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
`ifdef REGISTER_SERIAL_READER_PARITY_EN
            par_q  <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            done_q <= finish;
            if (load) begin
                shreg <= bus.ld_data;
                cnt   <= '0;
`ifdef REGISTER_SERIAL_READER_PARITY_EN
                par_q <= ^bus.ld_data;
`endif
            end else if (xfer && (state == SHIFT)) begin
                shreg <= shreg >> 1;
                cnt   <= cnt + 1'b1;
            end
        end
    end

    // ld_ready is the only output allowed to see reset combinationally.
    assign bus.ld_ready  = (state == IDLE) && !reset;
    assign bus.bit_valid = valid;
    assign bus.busy      = valid;
    assign bus.done      = done_q;
`ifdef REGISTER_SERIAL_READER_PARITY_EN
    assign bus.bit_data  = (state == PARITY) ? par_q : ((state == SHIFT) && shreg[0]);
    assign bus.bit_last  = (state == PARITY);
`else
    assign bus.bit_data  = (state == SHIFT) && shreg[0];
    assign bus.bit_last  = last_data;
`endif
endmodule
